crc32_stream: RTL and testbench

Parametrised streaming CRC-32 engine for the capture path: accepts a byte-lane data stream of `DATA_BYTES` lanes per beat, with per-lane keep, frame delimiting and abort. It produces a registered per-frame CRC, a residue check flag and a frame byte count. It supersedes the fixed 32-bit, free-running CRC block. It sits after packet reassembly, and both packet ECC/checksum verification and capture-buffer integrity tagging use it.

---
 rtl/crc32_stream.sv | 109 ++++++++++
 tb/tb_crc32_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: byte-lane beats with per-lane keep, frame delimiting
// and abort; registers a per-frame CRC, residue check flag and saturating byte count.
module crc32_stream #(
    parameter int unsigned DATA_BYTES = 4,
    parameter bit          REFLECT    = 1'b1,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic [8*DATA_BYTES-1:0]   s_data,
    input  logic [DATA_BYTES-1:0]     s_keep,
    input  logic                      s_last,
    input  logic                      abort,
    output logic                      crc_valid,
    output logic [31:0]               crc_out,
    output logic                      crc_ok,
    output logic [15:0]               byte_count
);

    function automatic logic [31:0] reverse32(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] POLY_REV = reverse32(POLY);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic [31:0] crc_next;
    logic [15:0] cnt_next;
    logic [4:0]  pop;
    logic [16:0] cnt_sum;

    // Lanes fold in ascending order; unkept lanes are skipped entirely.
    always_comb begin
        crc_next = (state == IDLE) ? INIT : crc_q;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (s_keep[k]) begin
                if (REFLECT) begin
                    crc_next = crc_next ^ {24'd0, s_data[8*k +: 8]};
                    for (int unsigned b = 0; b < 8; b++) begin
                        crc_next = crc_next[0] ? ((crc_next >> 1) ^ POLY_REV)
                                               : (crc_next >> 1);
                    end
                end else begin
                    crc_next = crc_next ^ {s_data[8*k +: 8], 24'd0};
                    for (int unsigned b = 0; b < 8; b++) begin
                        crc_next = crc_next[31] ? ((crc_next << 1) ^ POLY)
                                                : (crc_next << 1);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            pop = pop + 5'(s_keep[k]);
        end
        cnt_sum  = {1'b0, ((state == IDLE) ? 16'd0 : cnt_q)} + 17'(pop);
        cnt_next = cnt_sum[16] ? '1 : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc_q      <= INIT;
            cnt_q      <= '0;
            crc_valid  <= 1'b0;
            crc_out    <= '0;
            crc_ok     <= 1'b0;
            byte_count <= '0;
        end else begin
            crc_valid <= 1'b0;
            if (abort) begin
                state <= IDLE;
                crc_q <= INIT;
                cnt_q <= '0;
            end else if (s_valid) begin
                if (s_last) begin
                    state      <= IDLE;
                    crc_q      <= INIT;
                    cnt_q      <= '0;
                    crc_valid  <= 1'b1;
                    crc_out    <= crc_next ^ XOR_OUT;
                    crc_ok     <= (crc_next == RESIDUE);
                    byte_count <= cnt_next;
                end else begin
                    state <= ACTIVE;
                    crc_q <= crc_next;
                    cnt_q <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: randomized beats scored against a byte-queue CRC model,
// plus literal checks for reflected, non-reflected and byte-wide configurations.
module tb_crc32_stream;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_valid, s_last, abort;
    logic [31:0] s_data;
    logic [3:0]  s_keep;

    logic        crc_valid, crc_ok;
    logic [31:0] crc_out;
    logic [15:0] byte_count;
    logic        n_valid, n_ok;
    logic [31:0] n_crc;
    logic [15:0] n_count;
    logic        x_valid, x_ok;
    logic [31:0] x_crc;
    logic [15:0] x_count;

    logic        b_valid, b_last, b_abort, b_crc_valid, b_ok;
    logic [7:0]  b_data;
    logic [0:0]  b_keep;
    logic [31:0] b_crc;
    logic [15:0] b_count;

    crc32_stream dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .abort(abort), .crc_valid(crc_valid), .crc_out(crc_out),
        .crc_ok(crc_ok), .byte_count(byte_count)
    );

    crc32_stream #(.REFLECT(1'b0), .RESIDUE(32'hC704DD7B)) dut_n (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .abort(abort), .crc_valid(n_valid), .crc_out(n_crc),
        .crc_ok(n_ok), .byte_count(n_count)
    );

    crc32_stream #(.REFLECT(1'b0), .XOR_OUT(32'h0), .RESIDUE(32'hC704DD7B)) dut_nx (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .abort(abort), .crc_valid(x_valid), .crc_out(x_crc),
        .crc_ok(x_ok), .byte_count(x_count)
    );

    crc32_stream #(.DATA_BYTES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_data(b_data), .s_keep(b_keep),
        .s_last(b_last), .abort(b_abort), .crc_valid(b_crc_valid), .crc_out(b_crc),
        .crc_ok(b_ok), .byte_count(b_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Polynomial division in normal (MSB-first) form; the reflected CRC is the same
    // division over bit-reversed bytes, read back bit-reversed.
    function automatic logic [31:0] raw_crc(input bq_t q, input bit refl);
        logic [31:0] r;
        logic [7:0]  b;
        bit          fb;
        r = refl ? rev32(32'hFFFFFFFF) : 32'hFFFFFFFF;
        foreach (q[i]) begin
            b = refl ? rev8(q[i]) : q[i];
            for (int j = 7; j >= 0; j--) begin
                fb = r[31] ^ b[j];
                r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        return refl ? rev32(r) : r;
    endfunction

    // Reference model: collects the kept bytes of the current frame.
    bq_t         fq;
    logic        m_valid  = 1'b0;
    logic        m_ok     = 1'b0;
    logic        m_ok_n   = 1'b0;
    logic [31:0] m_crc    = '0;
    logic [31:0] m_crc_n  = '0;
    logic [31:0] m_crc_nx = '0;
    logic [15:0] m_cnt    = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] rr, rn;
        if (!rst_n) begin
            fq.delete();
            m_valid = 1'b0; m_ok = 1'b0; m_ok_n = 1'b0;
            m_crc = '0; m_crc_n = '0; m_crc_nx = '0; m_cnt = '0;
        end else begin
            m_valid = 1'b0;
            if (abort) begin
                fq.delete();
            end else if (s_valid) begin
                for (int k = 0; k < 4; k++) if (s_keep[k]) fq.push_back(s_data[8*k +: 8]);
                if (s_last) begin
                    rr       = raw_crc(fq, 1'b1);
                    rn       = raw_crc(fq, 1'b0);
                    m_valid  = 1'b1;
                    m_crc    = rr ^ 32'hFFFFFFFF;
                    m_ok     = (rr == 32'hDEBB20E3);
                    m_crc_n  = rn ^ 32'hFFFFFFFF;
                    m_crc_nx = rn;
                    m_ok_n   = (rn == 32'hC704DD7B);
                    m_cnt    = (fq.size() > 65535) ? 16'hFFFF : 16'(fq.size());
                    fq.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ref",  {14'd0, crc_valid, crc_ok, byte_count, crc_out},
                            {14'd0, m_valid, m_ok, m_cnt, m_crc});
            chk("cyc_nref", {14'd0, n_valid, n_ok, n_count, n_crc},
                            {14'd0, m_valid, m_ok_n, m_cnt, m_crc_n});
            chk("cyc_nx0",  {14'd0, x_valid, x_ok, x_count, x_crc},
                            {14'd0, m_valid, m_ok_n, m_cnt, m_crc_nx});
        end
    end

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic a);
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; abort = a;
        @(negedge clk);
        s_valid = 1'b0; s_keep = '0; s_last = 1'b0; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_check_string;
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat(32'h00000039, 4'h1, 1'b1, 1'b0);
    endtask

    logic [7:0] chkstr [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    initial begin
        bq_t q;
        rst_n = 1'b1;
        s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; abort = 1'b0;
        b_valid = 1'b0; b_data = '0; b_keep = '0; b_last = 1'b0; b_abort = 1'b0;

        // Pin the model against known check values.
        foreach (chkstr[i]) q.push_back(chkstr[i]);
        chk("pin_ref",   raw_crc(q, 1'b1) ^ 32'hFFFFFFFF, 32'hCBF43926);
        chk("pin_nref",  raw_crc(q, 1'b0) ^ 32'hFFFFFFFF, 32'hFC891918);
        chk("pin_nx0",   raw_crc(q, 1'b0),                32'h0376E6E7);
        q.delete(); q.push_back(8'h31);
        chk("pin_one",   raw_crc(q, 1'b1) ^ 32'hFFFFFFFF, 32'h83DCEFB7);

        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        idle(2);
        chk("reset_out", {crc_valid, crc_ok, byte_count, crc_out}, '0);
        rst_n = 1'b1;
        idle(1);

        // Check string, all three DB=4 configurations.
        send_check_string();
        chk("t1_valid", crc_valid, 1'b1);
        chk("t1_crc",   crc_out, 32'hCBF43926);
        chk("t1_count", byte_count, 16'd9);
        chk("t3_nref",  n_crc, 32'hFC891918);
        chk("t3_nx0",   x_crc, 32'h0376E6E7);
        idle(1);
        chk("t1_pulse_end", crc_valid, 1'b0);
        chk("hold_crc", crc_out, 32'hCBF43926);

        // Residue: reflected append, bit flip, then normal-form append.
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1, 1'b0);
        chk("t2_ok",    crc_ok, 1'b1);
        chk("t2_count", byte_count, 16'd13);
        beat(32'h34333230, 4'hF, 1'b0, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1, 1'b0);
        chk("t2_flip_ok", crc_ok, 1'b0);
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        beat(32'h1989FC39, 4'hF, 1'b0, 1'b0);
        beat(32'h00000018, 4'h1, 1'b1, 1'b0);
        chk("t3_nref_ok", n_ok, 1'b1);

        // Abort with last, abort without valid, then sparse keep with gaps.
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        beat(32'h38373635, 4'hF, 1'b1, 1'b1);
        chk("t4_abort_novalid", crc_valid, 1'b0);
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        abort = 1'b1; idle(1); abort = 1'b0;
        beat(32'hEE32FF31, 4'b0101, 1'b0, 1'b0);
        beat(32'h34AA33BB, 4'b1010, 1'b0, 1'b0);
        beat(32'hDEADBEEF, 4'b0000, 1'b0, 1'b0);
        idle(2);
        beat(32'hCC36DD35, 4'b0101, 1'b0, 1'b0);
        beat(32'h38AA37BB, 4'b1010, 1'b0, 1'b0);
        beat(32'h77665539, 4'b0001, 1'b1, 1'b0);
        chk("t4_sparse_crc",   crc_out, 32'hCBF43926);
        chk("t4_sparse_count", byte_count, 16'd9);

        // Back-to-back single-beat frames.
        beat(32'h00000031, 4'h1, 1'b1, 1'b0);
        chk("t5_first_valid", crc_valid, 1'b1);
        chk("t5_first_crc",   crc_out, 32'h83DCEFB7);
        beat(32'h00000031, 4'h1, 1'b1, 1'b0);
        chk("t5_second_valid", crc_valid, 1'b1);
        chk("t5_second_crc",   crc_out, 32'h83DCEFB7);

        // Byte-wide instance, with an idle cycle and an empty-keep beat mid-frame.
        foreach (chkstr[i]) begin
            b_valid = 1'b1; b_data = chkstr[i]; b_keep = 1'b1; b_last = (i == 8);
            @(negedge clk);
            b_valid = 1'b0; b_last = 1'b0;
            if (i == 4) begin
                idle(1);
                b_valid = 1'b1; b_keep = 1'b0; b_data = 8'hA5;
                @(negedge clk);
                b_valid = 1'b0;
            end
        end
        chk("t5_db1_valid", b_crc_valid, 1'b1);
        chk("t5_db1_crc",   b_crc, 32'hCBF43926);
        chk("t5_db1_count", b_count, 16'd9);
        idle(1);
        chk("t5_db1_pulse_end", b_crc_valid, 1'b0);

        // Asynchronous reset mid-frame.
        beat(32'h34333231, 4'hF, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_zero", {crc_valid, crc_ok, byte_count, crc_out}, '0);
        chk("t6_async_zero_b", {b_count, b_crc}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_check_string();
        chk("t6_after_crc", crc_out, 32'hCBF43926);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = $urandom;
            s_keep  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            s_last  = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; s_keep = '0;
        idle(2);

        // Long frame saturating the byte counter.
        for (int i = 0; i < 16400; i++) beat($urandom, 4'hF, 1'b0, 1'b0);
        beat($urandom, 4'hF, 1'b1, 1'b0);
        chk("sat_count", byte_count, 16'hFFFF);
        idle(3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
